// File: rtl/instr_encode.sv
// instr_encode: packs MIPS instruction fields into 32-bit words and streams them to instruction memory from BASE_ADDR through a FIFO; ENC_CHECKSUM_EN adds a running XOR checksum of written words.
module instr_encode #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 32,
    parameter int DEPTH = 4,
    parameter logic [AWIDTH-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_kind,
    input  logic [3:0]        in_op,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [15:0]       in_imm,
    input  logic [25:0]       in_target,
    output logic              imem_we,
    output logic [AWIDTH-1:0] imem_addr,
    output logic [DWIDTH-1:0] imem_wdata,
    input  logic              imem_ready,
    output logic              err,
    output logic [7:0]        err_cnt,
`ifdef ENC_CHECKSUM_EN
    output logic [31:0]       checksum,
`endif
    output logic [15:0]       wr_count
);
    localparam int PW = $clog2(DEPTH);

    logic [DWIDTH-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0] count;
    logic [6:0] fn;
    logic [5:0] opc;
    logic jr, legal, accept, push, pop;
    logic [DWIDTH-1:0] word;

    // fn carries {legal, funct}; unlisted ALU ops decode to zero and are dropped
    always_comb begin
        fn = in_op == 4'b0000 ? 7'b1_100100 :
             in_op == 4'b0001 ? 7'b1_100101 :
             in_op == 4'b0010 ? 7'b1_100000 :
             in_op == 4'b0110 ? 7'b1_100010 :
             in_op == 4'b1100 ? 7'b1_100111 :
             in_op == 4'b0111 ? 7'b1_101010 :
             in_op == 4'b1000 ? 7'b1_001000 : 7'b0;
        opc = in_kind == 3'd1 ? 6'b001000 :
              in_kind == 3'd2 ? 6'b001010 :
              in_kind == 3'd3 ? 6'b100011 :
              in_kind == 3'd4 ? 6'b101011 :
              in_kind == 3'd5 ? 6'b000100 :
              in_kind == 3'd6 ? 6'b000010 :
              in_kind == 3'd7 ? 6'b000011 : 6'b000000;
        jr = in_op == 4'b1000;
        legal = in_kind != 3'd0 || fn[6];
        word = in_kind == 3'd0 ? {6'b0, in_rs, jr ? 5'd0 : in_rt, jr ? 5'd0 : in_rd, 5'd0, fn[5:0]} :
               in_kind[2:1] == 2'b11 ? {opc, in_target} : {opc, in_rs, in_rt, in_imm};
    end

    assign in_ready = count < (PW+1)'(DEPTH);
    assign accept = in_valid && in_ready;
    assign push = accept && legal;
    assign imem_we = count != '0;
    assign pop = imem_we && imem_ready;
    assign imem_wdata = imem_we ? mem[rd_ptr] : '0;

    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= word;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
            imem_addr <= BASE_ADDR;
            err <= 1'b0;
            err_cnt <= '0;
            wr_count <= '0;
        end else begin
            wr_ptr <= wr_ptr + PW'(push);
            rd_ptr <= rd_ptr + PW'(pop);
            count <= count + (PW+1)'(push) - (PW+1)'(pop);
            imem_addr <= pop ? imem_addr + AWIDTH'(4) : imem_addr;
            err <= accept && !legal;
            err_cnt <= err_cnt + 8'(accept && !legal && err_cnt != 8'hFF);
            wr_count <= wr_count + 16'(pop);
        end
    end

`ifdef ENC_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (rst) checksum <= '0;
        else if (pop) checksum <= checksum ^ imem_wdata;
    end
`endif
endmodule

// File: tb/tb_instr_encode.sv
// tb_instr_encode: table vectors, corner sequences and randomized traffic against a queue-based reference model.
module tb_instr_encode;
    localparam int DEPTH = 4;

    logic clk, rst, in_valid, in_ready, imem_we, imem_ready, err;
    logic [2:0] in_kind;
    logic [3:0] in_op;
    logic [4:0] in_rs, in_rt, in_rd;
    logic [15:0] in_imm, wr_count;
    logic [25:0] in_target;
    logic [31:0] imem_addr, imem_wdata;
    logic [7:0] err_cnt;
`ifdef ENC_CHECKSUM_EN
    logic [31:0] checksum;
`endif

    instr_encode #(.DWIDTH(32), .AWIDTH(32), .DEPTH(DEPTH), .BASE_ADDR(32'h0)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_kind(in_kind), .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
        .in_imm(in_imm), .in_target(in_target), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .imem_ready(imem_ready), .err(err), .err_cnt(err_cnt),
`ifdef ENC_CHECKSUM_EN
        .checksum(checksum),
`endif
        .wr_count(wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // reference: opcodes by kind, funct by ALU op (missing key = illegal op)
    int opc_of [8] = '{0, 8, 10, 35, 43, 4, 2, 3};
    int funct_of [int];
    int legal_ops [7] = '{0, 1, 2, 6, 12, 7, 8};

    function automatic void model_enc(input logic [2:0] k, input logic [3:0] op,
                                      input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                                      input logic [15:0] imm, input logic [25:0] tg,
                                      output bit legal, output logic [31:0] w);
        longint v;
        legal = 1;
        if (k == 0) begin
            if (!funct_of.exists(int'(op))) begin
                legal = 0;
                v = 0;
            end else if (op == 4'd8) v = longint'(rs) * (1 << 21) + funct_of[int'(op)];
            else v = longint'(rs) * (1 << 21) + longint'(rt) * (1 << 16) + longint'(rd) * (1 << 11) + funct_of[int'(op)];
        end else if (k >= 6) v = longint'(opc_of[k]) * (1 << 26) + longint'(tg);
        else v = longint'(opc_of[k]) * (1 << 26) + longint'(rs) * (1 << 21) + longint'(rt) * (1 << 16) + longint'(imm);
        w = v[31:0];
    endfunction

    logic [31:0] q [$];
    logic [31:0] m_addr = 0, m_ck = 0;
    int m_wr = 0, m_errcnt = 0;
    bit m_err = 0;

    always @(negedge clk) begin : mon
        bit rdy, lg;
        logic [31:0] w;
        rdy = q.size() < DEPTH;
        chk("in_ready", 32'(in_ready), 32'(rdy));
        chk("imem_we", 32'(imem_we), 32'(q.size() != 0));
        if (q.size() != 0) begin
            chk("imem_wdata", imem_wdata, q[0]);
            chk("imem_addr", imem_addr, m_addr);
        end
        chk("err", 32'(err), 32'(m_err));
        chk("err_cnt", 32'(err_cnt), 32'(m_errcnt));
        chk("wr_count", 32'(wr_count), 32'(m_wr % 65536));
`ifdef ENC_CHECKSUM_EN
        chk("checksum", checksum, m_ck);
`endif
        if (rst) begin
            q.delete();
            m_addr = 0; m_ck = 0; m_wr = 0; m_errcnt = 0; m_err = 0;
        end else begin
            m_err = 0;
            if (imem_ready && q.size() != 0) begin
                m_ck ^= q[0];
                void'(q.pop_front());
                m_addr += 4;
                m_wr++;
            end
            if (in_valid && rdy) begin
                model_enc(in_kind, in_op, in_rs, in_rt, in_rd, in_imm, in_target, lg, w);
                if (lg) q.push_back(w);
                else begin
                    m_err = 1;
                    if (m_errcnt < 255) m_errcnt++;
                end
            end
        end
    end

    task automatic send(input logic [2:0] k, input logic [3:0] op, input logic [4:0] rs,
                        input logic [4:0] rt, input logic [4:0] rd, input logic [15:0] imm,
                        input logic [25:0] tg);
        @(posedge clk); #1;
        in_kind = k; in_op = op; in_rs = rs; in_rt = rt; in_rd = rd; in_imm = imm; in_target = tg;
        in_valid = 1;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk); #1;
                in_valid = 0;
                return;
            end
        end
        chk("send_timeout", 32'(in_ready), 32'd1);
        in_valid = 0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1; in_valid = 0;
        @(posedge clk); #1;
        rst = 0;
    endtask

    typedef struct {
        logic [2:0] k;
        logic [3:0] op;
        logic [4:0] rs, rt, rd;
        logic [15:0] imm;
        logic [25:0] tg;
        logic [31:0] exp;
    } vec_t;
    vec_t tbl [13];

    initial begin
        logic [31:0] w0;
        bit lg;
        funct_of[0] = 36; funct_of[1] = 37; funct_of[2] = 32; funct_of[6] = 34;
        funct_of[12] = 39; funct_of[7] = 42; funct_of[8] = 8;
        tbl[0]  = '{3'd0, 4'd2,  5'd1,  5'd2, 5'd3, 16'h0000, 26'h0,  32'h00221820};
        tbl[1]  = '{3'd1, 4'd0,  5'd0,  5'd2, 5'd0, 16'hFFFF, 26'h0,  32'h2002FFFF};
        tbl[2]  = '{3'd3, 4'd0,  5'd5,  5'd4, 5'd0, 16'h0008, 26'h0,  32'h8CA40008};
        tbl[3]  = '{3'd4, 4'd0,  5'd5,  5'd4, 5'd0, 16'h0008, 26'h0,  32'hACA40008};
        tbl[4]  = '{3'd5, 4'd0,  5'd1,  5'd2, 5'd0, 16'hFFFE, 26'h0,  32'h1022FFFE};
        tbl[5]  = '{3'd6, 4'd0,  5'd0,  5'd0, 5'd0, 16'h0000, 26'h10, 32'h08000010};
        tbl[6]  = '{3'd7, 4'd0,  5'd0,  5'd0, 5'd0, 16'h0000, 26'h10, 32'h0C000010};
        tbl[7]  = '{3'd0, 4'd8,  5'd31, 5'd7, 5'd9, 16'h0000, 26'h0,  32'h03E00008};
        tbl[8]  = '{3'd2, 4'd0,  5'd3,  5'd4, 5'd0, 16'h0005, 26'h0,  32'h28640005};
        tbl[9]  = '{3'd0, 4'd6,  5'd1,  5'd2, 5'd3, 16'h0000, 26'h0,  32'h00221822};
        tbl[10] = '{3'd0, 4'd0,  5'd1,  5'd2, 5'd3, 16'h0000, 26'h0,  32'h00221824};
        tbl[11] = '{3'd0, 4'd1,  5'd1,  5'd2, 5'd3, 16'h0000, 26'h0,  32'h00221825};
        tbl[12] = '{3'd0, 4'd12, 5'd1,  5'd2, 5'd3, 16'h0000, 26'h0,  32'h00221827};
        rst = 1; in_valid = 0; imem_ready = 1;
        in_kind = 0; in_op = 0; in_rs = 0; in_rt = 0; in_rd = 0; in_imm = 0; in_target = 0;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_imem_we", 32'(imem_we), 32'd0);
        chk("reset_wdata", imem_wdata, 32'd0);

        for (int i = 0; i < 13; i++) begin
            send(tbl[i].k, tbl[i].op, tbl[i].rs, tbl[i].rt, tbl[i].rd, tbl[i].imm, tbl[i].tg);
            @(negedge clk);
            chk("tbl_we", 32'(imem_we), 32'd1);
            chk("tbl_word", imem_wdata, tbl[i].exp);
            chk("tbl_addr", imem_addr, 32'(4 * i));
        end
        @(negedge clk);
        chk("tbl_wr_count", 32'(wr_count), 32'd13);

        // stall memory: fifth request must wait for space
        imem_ready = 0;
        model_enc(3'd0, 4'd2, 5'd1, 5'd2, 5'd0, 16'h0, 26'h0, lg, w0);
        fork
            for (int i = 0; i < 5; i++) send(3'd0, 4'd2, 5'd1, 5'd2, 5'(i), 16'h0, 26'h0);
            begin
                repeat (16) @(negedge clk);
                chk("full_in_ready", 32'(in_ready), 32'd0);
                chk("hold_wdata", imem_wdata, w0);
                chk("hold_addr", imem_addr, 32'h34);
                @(posedge clk); #1 imem_ready = 1;
            end
        join
        repeat (4) @(negedge clk);
        chk("stall_wr_count", 32'(wr_count), 32'd18);

        send(3'd0, 4'd3, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
        @(negedge clk);
        chk("illegal_err", 32'(err), 32'd1);
        chk("illegal_we", 32'(imem_we), 32'd0);
        chk("illegal_cnt", 32'(err_cnt), 32'd1);
        @(negedge clk);
        chk("illegal_err_clr", 32'(err), 32'd0);
        for (int i = 0; i < 300; i++) send(3'd0, 4'(i % 2 ? 5 : 15), 5'd0, 5'd0, 5'd0, 16'h0, 26'h0);
        @(negedge clk);
        chk("err_cnt_sat", 32'(err_cnt), 32'd255);

        imem_ready = 0;
        for (int i = 0; i < 3; i++) send(3'd1, 4'd0, 5'd1, 5'd1, 5'd0, 16'(i), 26'h0);
        do_reset();
        imem_ready = 1;
        @(negedge clk);
        chk("rst_we", 32'(imem_we), 32'd0);
        chk("rst_addr", imem_addr, 32'd0);
        chk("rst_err_cnt", 32'(err_cnt), 32'd0);

`ifdef ENC_CHECKSUM_EN
        send(3'd0, 4'd2, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
        send(3'd1, 4'd0, 5'd0, 5'd2, 5'd0, 16'hFFFF, 26'h0);
        repeat (2) @(negedge clk);
        chk("checksum_pair", checksum, 32'h2020E7DF);
`endif

        for (int c = 0; c < 800; c++) begin
            @(posedge clk); #1;
            in_valid = 1'($urandom_range(0, 1));
            in_kind = 3'($urandom);
            in_op = $urandom_range(0, 7) == 0 ? 4'($urandom) : 4'(legal_ops[$urandom_range(0, 6)]);
            in_rs = 5'($urandom); in_rt = 5'($urandom); in_rd = 5'($urandom);
            in_imm = 16'($urandom); in_target = 26'($urandom);
            imem_ready = $urandom_range(0, 3) != 0;
        end
        @(posedge clk); #1;
        in_valid = 0; imem_ready = 1;
        repeat (DEPTH + 4) @(posedge clk);
        @(negedge clk);
        chk("drained", 32'(imem_we), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
